// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulate stage.
package mac_pkg;

  localparam int unsigned M      = 4;
  localparam int unsigned N      = 3;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PROD_W = M + N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_acc_add.sv
// ACC_W-bit accumulator adder with carry out.
// ACC_SATURATE_EN: clamp the sum to all-ones on carry instead of wrapping.
module mac_acc_add #(
  parameter int unsigned ACC_W = mac_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum_c,
  output logic             carry_c
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry_c  = full_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so the clamp holds for the frame.
  assign sum_c = carry_c ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_c = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator downstream of the M-by-N multiplier: sums products until in_last,
// then holds sum/count/overflow under valid/ready. Wrap vs clamp set by ACC_SATURATE_EN.
module mac_accumulator #(
  parameter int unsigned M     = mac_pkg::M,
  parameter int unsigned N     = mac_pkg::N,
  parameter int unsigned ACC_W = mac_pkg::ACC_W,
  parameter int unsigned CNT_W = mac_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M+N-1:0]   prod_i,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             out_valid,
  input  logic             out_ready
);

  import mac_pkg::*;

  if (ACC_W < M + N) begin : g_width_check
    $error("mac_accumulator: ACC_W must be >= M+N");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign prod_ext = ACC_W'(prod_i);

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .a       (acc_o),
    .b       (prod_ext),
    .sum_c   (add_sum),
    .carry_c (add_carry)
  );

  // Next-state and next-value decode.
  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_o;
    cnt_nxt   = count_o;
    ovf_nxt   = overflow_o;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_nxt   = prod_ext;
          cnt_nxt   = CNT_W'(1);
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt   = add_sum;
          ovf_nxt   = overflow_o | add_carry;
          cnt_nxt   = (count_o == CNT_MAX) ? count_o : count_o + CNT_W'(1);
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_o      <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      acc_o      <= acc_nxt;
      count_o    <= cnt_nxt;
      overflow_o <= ovf_nxt;
      out_valid  <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 16-bit and an 8-bit accumulator run in lockstep
// on shared stimulus, checked against a frame-sum reference model.
module tb_mac_accumulator;

  localparam int unsigned PW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] prod_i;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;

  logic          in_ready16, in_ready8;
  logic          out_valid16, out_valid8;
  logic          ovf16, ovf8;
  logic [15:0]   acc16;
  logic [7:0]    acc8;
  logic [7:0]    cnt16, cnt8;

  always #5 clk = ~clk;

  mac_accumulator #(.M(4), .N(3), .ACC_W(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .prod_i(prod_i), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready16), .acc_o(acc16), .count_o(cnt16), .overflow_o(ovf16),
    .out_valid(out_valid16), .out_ready(out_ready)
  );

  mac_accumulator #(.M(4), .N(3), .ACC_W(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .prod_i(prod_i), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready8), .acc_o(acc8), .count_o(cnt8), .overflow_o(ovf8),
    .out_valid(out_valid8), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: true frame sum, product count, and whether a result is held.
  bit     m_hold = 1'b0;
  longint m_sum  = 0;
  int     m_n    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint exp_acc(input longint s, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (s <= mx) return s;
`ifdef ACC_SATURATE_EN
    return mx;
`else
    return s & mx;
`endif
  endfunction

  function automatic int exp_cnt(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic tick();
    chk("in_ready16",  in_ready16,  !m_hold);
    chk("in_ready8",   in_ready8,   !m_hold);
    chk("out_valid16", out_valid16, m_hold);
    chk("out_valid8",  out_valid8,  m_hold);
    chk("acc16",       acc16,       exp_acc(m_sum, 16));
    chk("acc8",        acc8,        exp_acc(m_sum, 8));
    chk("ovf16",       ovf16,       m_sum > 65535);
    chk("ovf8",        ovf8,        m_sum > 255);
    chk("cnt16",       cnt16,       exp_cnt(m_n));
    chk("cnt8",        cnt8,        exp_cnt(m_n));
    @(posedge clk);
    if (rst) begin
      m_hold = 1'b0; m_sum = 0; m_n = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0; m_sum = 0; m_n = 0;
      end
    end else if (in_valid) begin
      m_sum += longint'(prod_i);
      m_n++;
      if (in_last) m_hold = 1'b1;
    end
    #1;
  endtask

  task automatic send(input int p, input bit last);
    in_valid = 1'b1;
    prod_i   = PW'(p);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int len;
    rst = 1'b1; in_valid = 1'b1; prod_i = PW'(5); in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_acc", acc16, 0);
    chk("rst_cnt", cnt16, 0);
    chk("rst_in_ready", in_ready16, 1);

    // Basic frame, released immediately.
    out_ready = 1'b1;
    send(12, 0); send(5, 0); send(21, 1);
    chk("t2_valid", out_valid16, 1);
    chk("t2_acc", acc16, 38);
    chk("t2_cnt", cnt16, 3);
    chk("t2_ovf", ovf16, 0);
    tick();
    chk("t2_idle_valid", out_valid16, 0);
    chk("t2_idle_ready", in_ready16, 1);

    // Consumer stalls; inputs during HOLD and the release cycle are ignored.
    out_ready = 1'b0;
    send(12, 0); send(5, 0); send(21, 1);
    in_valid = 1'b1; prod_i = PW'(9); in_last = 1'b0;
    repeat (4) begin
      chk("t3_ready", in_ready16, 0);
      chk("t3_acc", acc16, 38);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_rel_ready", in_ready16, 1);
    chk("t3_rel_acc", acc16, 0);
    tick();
    in_valid = 1'b0;
    chk("t3_fresh_acc", acc16, 9);
    chk("t3_fresh_cnt", cnt16, 1);
    send(0, 1);
    tick();

    // Overflow on the 8-bit instance.
    send(100, 0); send(100, 0); send(100, 1);
`ifdef ACC_SATURATE_EN
    chk("t4_acc8", acc8, 255);
`else
    chk("t4_acc8", acc8, 44);
`endif
    chk("t4_ovf8", ovf8, 1);
    chk("t4_acc16", acc16, 300);
    chk("t4_ovf16", ovf16, 0);
    tick();

    // Single-product frame.
    send(42, 1);
    chk("t5_valid", out_valid16, 1);
    chk("t5_acc", acc16, 42);
    chk("t5_cnt", cnt16, 1);
    tick();

    // Reset mid-frame discards partial state.
    send(50, 0); send(60, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    send(7, 1);
    chk("t6_acc", acc16, 7);
    chk("t6_cnt", cnt16, 1);
    chk("t6_ovf", ovf16, 0);
    tick();

    // Randomized frames; frame 40 is long enough to saturate count and overflow 16 bits.
    for (int f = 0; f < 120; f++) begin
      len = (f == 40) ? 600 : int'($urandom_range(1, 10));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          out_ready = 1'(($urandom_range(0, 1)));
          tick();
        end
        rst       = (f != 40) && ($urandom_range(0, 199) == 0);
        prod_i    = (f == 40) ? PW'(127) : PW'($urandom_range(0, 127));
        in_valid  = 1'b1;
        in_last   = (k == len - 1);
        out_ready = 1'(($urandom_range(0, 1)));
        tick();
        rst = 1'b0;
      end
      in_last = 1'b0;
      if (f == 40) begin
        chk("long_cnt_sat", cnt16, 255);
        chk("long_ovf16", ovf16, 1);
      end
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'(($urandom_range(0, 1)));
        prod_i   = PW'($urandom_range(0, 127));
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
